// File: rtl/gost_89_gamma_ctrl.sv
// rtl/gost_89_gamma_ctrl.sv - GOST 28147-89 gamma (counter) mode controller around the cipher core
module gost_89_gamma_ctrl #(
    parameter logic [31:0] C1 = 32'h01010104,
    parameter logic [31:0] C2 = 32'h01010101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iv_valid,
    input  logic [63:0] iv,
    output logic        iv_ready,
    input  logic        din_valid,
    input  logic [63:0] din,
    output logic        din_ready,
    output logic        dout_valid,
    output logic [63:0] dout,
    input  logic        dout_ready,
    output logic        busy,
    output logic        core_load,
    output logic        core_mode,
    output logic [63:0] core_pdata,
    input  logic        core_done,
    input  logic [63:0] core_cdata
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT_LOAD = 3'd1,
        INIT_WAIT = 3'd2,
        READY     = 3'd3,
        BLK_LOAD  = 3'd4,
        BLK_WAIT  = 3'd5,
        OUT       = 3'd6
    } state_t;

    state_t      state;
    logic [31:0] n3;
    logic [31:0] n4;
    logic [63:0] data_q;
    logic [5:0]  wait_cnt;

    logic        done_ok;
    logic [32:0] n4_sum;
    logic [31:0] n4_step;
    logic [31:0] n3_step;

    // The core's done is free-running; only a pulse at least two cycles
    // after our load belongs to the run we started.
    assign done_ok = core_done && (wait_cnt >= 6'd2);

    // N4 adds modulo 2^32-1 via end-around carry; the carry never ripples
    // twice, so 0xFFFFFFFF survives as a legal value.
    assign n4_sum  = {1'b0, n4} + {1'b0, C1};
    assign n4_step = n4_sum[31:0] + {31'd0, n4_sum[32]};
    assign n3_step = n3 + C2;

    assign iv_ready   = (state == IDLE) || (state == READY);
    assign din_ready  = (state == READY);
    assign busy       = !iv_ready;
    assign core_mode  = 1'b0;
    assign core_pdata = {n4, n3};

    // Control FSM: synchro load, initial encryption, per-block counter step and gamma XOR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            n3         <= 32'd0;
            n4         <= 32'd0;
            data_q     <= 64'd0;
            dout       <= 64'd0;
            dout_valid <= 1'b0;
            core_load  <= 1'b0;
            wait_cnt   <= 6'd0;
        end else begin
            core_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (iv_valid) begin
                        {n4, n3}  <= iv;
                        core_load <= 1'b1;
                        state     <= INIT_LOAD;
                    end
                end
                INIT_LOAD: begin
                    wait_cnt <= 6'd0;
                    state    <= INIT_WAIT;
                end
                INIT_WAIT: begin
                    if (done_ok) begin
                        {n4, n3} <= core_cdata;
                        state    <= READY;
                    end else if (wait_cnt == 6'd63) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 6'd1;
                    end
                end
                READY: begin
                    // A new synchro wins over a pending data block.
                    if (iv_valid) begin
                        {n4, n3}  <= iv;
                        core_load <= 1'b1;
                        state     <= INIT_LOAD;
                    end else if (din_valid) begin
                        data_q    <= din;
                        n3        <= n3_step;
                        n4        <= n4_step;
                        core_load <= 1'b1;
                        state     <= BLK_LOAD;
                    end
                end
                BLK_LOAD: begin
                    wait_cnt <= 6'd0;
                    state    <= BLK_WAIT;
                end
                BLK_WAIT: begin
                    if (done_ok) begin
                        dout       <= data_q ^ core_cdata;
                        dout_valid <= 1'b1;
                        state      <= OUT;
                    end else if (wait_cnt == 6'd63) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 6'd1;
                    end
                end
                OUT: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        state      <= READY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
